// File: rtl/bus_cmd_initiator.sv
// Initiator for the 4-bit address/data/valid/ack register bus.
// Takes one upstream command at a time and drives it onto the bus.
// It then waits for the responder's ack, or gives up after TIMEOUT_CYCLES.
// Read data returned alongside the ack is captured, and completion or
// timeout is reported upstream as single-cycle pulses.
module bus_cmd_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter logic [3:0]  POSTED_ADDR    = 4'b0000,
    parameter logic [3:0]  QUERY_CODE     = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_addr,
    input  logic [3:0] cmd_data,
    output logic [3:0] address,
    output logic [3:0] data,
    output logic       valid,
    input  logic       ack,
    input  logic [3:0] rsp_data,
    input  logic       rsp_valid,
    output logic [3:0] rd_data,
    output logic       rd_valid,
    output logic       cmd_done,
    output logic       timeout_err
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] REQ    = 2'b01;
    localparam logic [1:0] POSTED = 2'b10;
    localparam logic [1:0] GAP    = 2'b11;

    // Last counter value before giving up; valid is then high TIMEOUT_CYCLES cycles.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] addr_q, addr_d;
    logic [3:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       done_q, done_d;
    logic       to_q, to_d;

    // The query code only tells the responder to return data. Capture is
    // keyed on rsp_valid alone, so the initiator never decodes it.
    logic unused_query_code;
    assign unused_query_code = ^QUERY_CODE;

    // Next-state and output decode for the command FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        to_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    data_d  = cmd_data;
                    valid_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = (cmd_addr == POSTED_ADDR) ? POSTED : REQ;
                end
            end
            POSTED: begin
                // The responder never acks this address, so it completes after one strobe.
                valid_d = 1'b0;
                done_d  = 1'b1;
                state_d = GAP;
            end
            REQ: begin
                // An ack takes priority over a timeout on the same edge.
                if (ack) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = GAP;
                    if (rsp_valid) begin
                        rd_data_d  = rsp_data;
                        rd_valid_d = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    valid_d = 1'b0;
                    to_d    = 1'b1;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                // One idle bus cycle so the responder drops its ack before the next strobe.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops valid at once with no pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= 4'd0;
            data_q     <= 4'd0;
            valid_q    <= 1'b0;
            cnt_q      <= 8'd0;
            rd_data_q  <= 4'd0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            to_q       <= to_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign address     = addr_q;
    assign data        = data_q;
    assign valid       = valid_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign cmd_done    = done_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_bus_cmd_initiator.sv
// Directed bench for bus_cmd_initiator, with a small registered responder model.
module tb_bus_cmd_initiator;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_data;
    logic [3:0] address;
    logic [3:0] data;
    logic       valid;
    logic       ack;
    logic [3:0] rsp_data;
    logic       rsp_valid;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic       cmd_done;
    logic       timeout_err;

    // Responder model: acks one cycle after seeing valid, and never acks address 0.
    logic       resp_en;
    logic       resp_ack_q;
    logic       resp_rv_q;
    logic       tb_ack;
    logic       tb_rv;
    logic [3:0] rsp_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_cmd_initiator #(
        .TIMEOUT_CYCLES(15),
        .POSTED_ADDR   (4'b0000),
        .QUERY_CODE    (4'b1111)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .address    (address),
        .data       (data),
        .valid      (valid),
        .ack        (ack),
        .rsp_data   (rsp_data),
        .rsp_valid  (rsp_valid),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .cmd_done   (cmd_done),
        .timeout_err(timeout_err)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_ack_q <= 1'b0;
            resp_rv_q  <= 1'b0;
        end else begin
            resp_ack_q <= valid && !resp_ack_q && resp_en && (address != 4'd0);
            resp_rv_q  <= valid && !resp_ack_q && resp_en && (address != 4'd0) && (data == 4'hF);
        end
    end

    assign ack       = resp_ack_q | tb_ack;
    assign rsp_valid = resp_rv_q | tb_rv;
    assign rsp_data  = rsp_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command and record, in cycles after the accept edge, when each event was seen.
    task automatic do_cmd(input logic [3:0] a, input logic [3:0] d, input int late_k,
                          output int vcnt, output int done_k, output int to_k,
                          output int rdv_k, output int ready_k);
        vcnt = 0; done_k = 0; to_k = 0; rdv_k = 0; ready_k = 0;
        @(negedge clk);
        for (int w = 0; w < 20 && !cmd_ready; w++) @(negedge clk);
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (valid)       vcnt++;
            if (cmd_done)    done_k = k;
            if (timeout_err) to_k = k;
            if (rd_valid)    rdv_k = k;
            if (cmd_ready) begin
                ready_k = k;
                break;
            end
            tb_ack = (k == late_k);
            @(negedge clk);
        end
        tb_ack = 1'b0;
        if (ready_k == 0) chk("cmd_budget", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc, dk, tk, rk, yk;
        int rises, acks, dones, lows;
        logic prev;

        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 4'd0; cmd_data = 4'd0;
        resp_en = 1'b0; tb_ack = 1'b0; tb_rv = 1'b0; rsp_val = 4'b0010;
        repeat (2) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_addr", address, 0);
        chk("rst_data", data, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_pulses", {rd_valid, cmd_done, timeout_err}, 0);
        rst = 1'b0;

        // 1: acked write
        resp_en = 1'b1;
        do_cmd(4'd2, 4'd1, 0, vc, dk, tk, rk, yk);
        chk("wr_valid_cycles", vc, 2);
        chk("wr_done_at", dk, 3);
        chk("wr_rd_valid", rk, 0);
        chk("wr_timeout", tk, 0);
        chk("wr_ready_at", yk, 4);
        chk("wr_addr_hold", address, 2);
        chk("wr_data_hold", data, 1);

        // 2: query with read data
        do_cmd(4'd2, 4'hF, 0, vc, dk, tk, rk, yk);
        chk("q_valid_cycles", vc, 2);
        chk("q_done_at", dk, 3);
        chk("q_rd_valid_at", rk, 3);
        chk("q_rd_data", rd_data, 2);

        // 3: posted write
        do_cmd(4'd0, 4'd5, 0, vc, dk, tk, rk, yk);
        chk("p_valid_cycles", vc, 1);
        chk("p_done_at", dk, 2);
        chk("p_ready_at", yk, 3);
        chk("p_rd_data_hold", rd_data, 2);

        // 4: no ack -> timeout
        resp_en = 1'b0;
        do_cmd(4'd3, 4'd1, 0, vc, dk, tk, rk, yk);
        chk("to_valid_cycles", vc, 15);
        chk("to_err_at", tk, 16);
        chk("to_no_done", dk, 0);
        chk("to_ready_at", yk, 17);

        // 4b: ack on the final cycle beats the timeout
        do_cmd(4'd3, 4'd2, 15, vc, dk, tk, rk, yk);
        chk("late_valid_cycles", vc, 15);
        chk("late_done_at", dk, 16);
        chk("late_no_timeout", tk, 0);

        // 5: back-to-back with cmd_valid held high
        resp_en = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 20 && !cmd_ready; w++) @(negedge clk);
        cmd_addr = 4'd4; cmd_data = 4'd3; cmd_valid = 1'b1;
        prev = valid; rises = 0; acks = 0; dones = 0; lows = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (valid && !prev) rises++;
            if (ack)      acks++;
            if (cmd_done) dones++;
            if (!valid)   lows++;
            prev = valid;
        end
        cmd_valid = 1'b0;
        chk("b2b_requests", rises, 3);
        chk("b2b_acks", acks, 3);
        chk("b2b_dones", dones, 3);
        chk("b2b_low_cycles", lows, 6);

        // 6: reset in REQ, then a stray ack and rsp_valid
        resp_en = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 20 && !cmd_ready; w++) @(negedge clk);
        cmd_addr = 4'd5; cmd_data = 4'd1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rr_valid_before", valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rr_valid_async", valid, 0);
        chk("rr_ready_async", cmd_ready, 1);
        chk("rr_no_done", cmd_done, 0);
        @(negedge clk);
        rst = 1'b0;
        tb_ack = 1'b1; tb_rv = 1'b1; rsp_val = 4'd7;
        @(negedge clk);
        tb_ack = 1'b0; tb_rv = 1'b0;
        chk("stray_pulses", {rd_valid, cmd_done, timeout_err}, 0);
        chk("stray_rd_data", rd_data, 0);
        chk("stray_valid", valid, 0);
        chk("stray_ready", cmd_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
